// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the program-counter / instruction-fetch block.
package pc_fetch_unit_pkg;

    // Next-PC select encodings driven by the control/branch logic
    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_J   = 2'b10;
    localparam logic [1:0] PC_SRC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StHold = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// 4:1 next-PC selector: sequential, branch, jump, jump-register.
module pc_next_mux
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_seq,
    input  logic [WIDTH-1:0] i_br,
    input  logic [WIDTH-1:0] i_j,
    input  logic [WIDTH-1:0] i_jr,
    output logic [WIDTH-1:0] o_y
);

    // Select the candidate named by i_sel
    always_comb begin
        o_y = i_seq;
        case (i_sel)
            PC_SRC_SEQ: o_y = i_seq;
            PC_SRC_BR:  o_y = i_br;
            PC_SRC_J:   o_y = i_j;
            PC_SRC_JR:  o_y = i_jr;
            default:    o_y = i_seq;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding fetch sequencer feeding decode through a one-entry buffer.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [1:0]         i_pc_src,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_branch_target,
    input  logic [25:0]        i_jump_index,
    input  logic [ADDR_W-1:0]  i_jr_addr,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic               o_imem_req,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_dec_valid,
    input  logic               i_dec_ready,
    output logic [INSTR_W-1:0] o_dec_instr,
    output logic [ADDR_W-1:0]  o_dec_pc
);

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_kill;
    logic               r_dec_valid;
    logic [INSTR_W-1:0] r_buf_instr;
    logic [ADDR_W-1:0]  r_buf_pc;

    logic [ADDR_W-1:0]  w_pc_plus4;
    logic [ADDR_W-1:0]  w_br;
    logic [ADDR_W-1:0]  w_jump;
    logic [ADDR_W-1:0]  w_jr;
    logic [ADDR_W-1:0]  w_target;
    logic               w_redirect;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_br       = i_branch_target & ~ADDR_W'(3);
    assign w_jr       = i_jr_addr & ~ADDR_W'(3);
    assign w_jump     = {w_pc_plus4[ADDR_W-1:28], i_jump_index, 2'b00};

    // A redirect selecting PC+4 changes nothing, so it is not treated as a redirect
    assign w_redirect = i_redirect && (i_pc_src != PC_SRC_SEQ);

    pc_next_mux #(
        .WIDTH (ADDR_W)
    ) u_pc_next_mux (
        .i_sel (i_pc_src),
        .i_seq (w_pc_plus4),
        .i_br  (w_br),
        .i_j   (w_jump),
        .i_jr  (w_jr),
        .o_y   (w_target)
    );

    // Fetch FSM, PC register, kill flag and decode buffer
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_dec_valid <= 1'b0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
        end else begin
            if (w_redirect) begin
                r_pc <= w_target;
            end
            case (r_state)
                StIdle: r_state <= StReq;
                StReq: begin
                    if (i_imem_gnt) begin
                        r_state <= StWait;
                        // Granted fetch targets the old PC: its data must be discarded
                        r_kill  <= w_redirect;
                    end
                end
                StWait: begin
                    if (i_imem_rvalid) begin
                        if (r_kill || w_redirect) begin
                            r_kill  <= 1'b0;
                            r_state <= StReq;
                        end else begin
                            r_buf_instr <= i_imem_rdata;
                            r_buf_pc    <= r_pc;
                            r_pc        <= w_pc_plus4;
                            r_dec_valid <= 1'b1;
                            r_state     <= StHold;
                        end
                    end else if (w_redirect) begin
                        r_kill <= 1'b1;
                    end
                end
                StHold: begin
                    if (w_redirect || i_dec_ready) begin
                        r_dec_valid <= 1'b0;
                        r_state     <= StReq;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_imem_req  = (r_state == StReq);
    assign o_imem_addr = r_pc;
    assign o_dec_valid = r_dec_valid;
    assign o_dec_instr = r_buf_instr;
    assign o_dec_pc    = r_buf_pc;

endmodule
